// File: rtl/keypad_matrix_emulator_pkg.sv
// Shared types and constants for the 4x4 keypad matrix emulator and its scanner-side decode.
// Holds the FSM state enum, key-code slice helpers and the default 50 MHz timing.
package keypad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESS_B,
    ST_HOLD,
    ST_REL_B,
    ST_GAP
  } state_t;

  localparam logic [3:0] IDLE_ROWS = 4'b1111;

  // Defaults for a 50 MHz clock: 40 ms hold clears a 20 ms debounce with margin.
  localparam int          DEF_CNT_W         = 22;
  localparam int unsigned DEF_HOLD_CYCLES   = 2_000_000;
  localparam int unsigned DEF_GAP_CYCLES    = 2_000_000;
  localparam int unsigned DEF_BOUNCE_CYCLES = 50_000;

  function automatic logic [1:0] KEY_ROW(input logic [3:0] key);
    return key[3:2];
  endfunction

  function automatic logic [1:0] KEY_COL(input logic [3:0] key);
    return key[1:0];
  endfunction

endpackage

// File: rtl/keypad_matrix_emulator_if.sv
// Command handshake and keypad matrix lines between a test driver and the emulator.
// The master side issues key presses and strobes columns; the slave side is the emulator.
interface keypad_matrix_emulator_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_key;
  logic [3:0] col_i;
  logic [3:0] row_o;
  logic       busy;
  logic       done;

  modport master (
    output cmd_valid,
    output cmd_key,
    output col_i,
    input  cmd_ready,
    input  row_o,
    input  busy,
    input  done
  );

  modport slave (
    input  cmd_valid,
    input  cmd_key,
    input  col_i,
    output cmd_ready,
    output row_o,
    output busy,
    output done
  );

endinterface

// File: rtl/keypad_matrix_emulator_lfsr.sv
// Free-running 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1) used as
// contact chatter source; only instantiated when KEYPAD_EMU_BOUNCE_EN is defined.
module keypad_bounce_lfsr (
  input  logic clk,
  input  logic reset,
  output logic bit_o
);

  logic [15:0] lfsr;
  logic        feedback;

  assign feedback = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[14:0], feedback};
    end
  end

  assign bit_o = lfsr[0];

endmodule

// File: rtl/keypad_matrix_emulator.sv
// Emulates one key of a 4x4 active-low matrix keypad: press, hold, release, gap per command.
// Optional contact chatter during press/release is enabled by KEYPAD_EMU_BOUNCE_EN.
module keypad_matrix_emulator
  import keypad_pkg::*;
#(
  parameter int          CNT_W         = DEF_CNT_W,
  parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int unsigned GAP_CYCLES    = DEF_GAP_CYCLES,
  parameter int unsigned BOUNCE_CYCLES = DEF_BOUNCE_CYCLES
) (
  input  logic                      clk,
  input  logic                      reset,
  keypad_matrix_emulator_if.slave   bus
);

  localparam longint unsigned CNT_LIMIT = 64'd1 << CNT_W;

  if (longint'(HOLD_CYCLES) > CNT_LIMIT || longint'(GAP_CYCLES) > CNT_LIMIT ||
      longint'(BOUNCE_CYCLES) > CNT_LIMIT) begin : g_param_check
    $error("keypad_matrix_emulator: timing parameter exceeds 2**CNT_W");
  end

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt;
  logic [3:0]         key_r;
  logic               contact;
  logic               done_c;
  logic               bounce_contact;
  logic               bounce_last;
  logic [3:0]         rows;

`ifdef KEYPAD_EMU_BOUNCE_EN
  logic lfsr_bit;

  keypad_bounce_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .bit_o (lfsr_bit)
  );

  assign bounce_contact = lfsr_bit;
  assign bounce_last    = (cnt == CNT_W'(BOUNCE_CYCLES - 1));
`else
  // Without chatter the bounce states collapse to a single open-contact cycle.
  assign bounce_contact = 1'b0;
  assign bounce_last    = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      key_r <= '0;
    end else begin
      state <= state_next;
      // Counter restarts on every state change and rests at zero while idle.
      if (state_next != state || state == ST_IDLE) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (state == ST_IDLE && bus.cmd_valid) begin
        key_r <= bus.cmd_key;
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    contact    = 1'b0;
    done_c     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.cmd_valid) state_next = ST_PRESS_B;
      end
      ST_PRESS_B: begin
        contact = bounce_contact;
        if (bounce_last) state_next = ST_HOLD;
      end
      ST_HOLD: begin
        contact = 1'b1;
        if (cnt == CNT_W'(HOLD_CYCLES - 1)) state_next = ST_REL_B;
      end
      ST_REL_B: begin
        contact = bounce_contact;
        if (bounce_last) state_next = ST_GAP;
      end
      ST_GAP: begin
        if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
          state_next = ST_IDLE;
          done_c     = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Row path stays combinational: the scanner reads rows one cycle after moving columns.
  always_comb begin
    rows = IDLE_ROWS;
    if (contact && !bus.col_i[KEY_COL(key_r)]) begin
      rows[KEY_ROW(key_r)] = 1'b0;
    end
  end

  assign bus.row_o     = rows;
  assign bus.cmd_ready = (state == ST_IDLE);
  assign bus.busy      = (state != ST_IDLE);
  assign bus.done      = done_c;

endmodule
